// File: rtl/miner_pkg.sv
// Shared definitions for the miner job scheduler: 608-bit header layout, FSM encoding and ARM watchdog length.
package miner_pkg;

  localparam int HDR_WORDS         = 19;
  localparam int HDR_W             = 32 * HDR_WORDS;
  localparam int HDR_VERSION       = 0;
  localparam int HDR_PREV_HASH_0   = 1;
  localparam int HDR_MERKLE_ROOT_0 = 9;
  localparam int HDR_BTIME         = 17;
  localparam int HDR_BITS          = 18;

  localparam int ARM_TIMEOUT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_ARM    = 3'd2,
    ST_RUN    = 3'd3,
    ST_REPORT = 3'd4
  } sched_state_t;

  // Word 0 sits at the top of the bus.
  function automatic int hdr_msb(input int word);
    return HDR_W - 1 - 32 * word;
  endfunction

  localparam int BTIME_MSB = hdr_msb(HDR_BTIME);
  localparam int BITS_MSB  = hdr_msb(HDR_BITS);

endpackage

// File: rtl/miner_job_buf.sv
// Two-entry job holder: an active slot feeding the core and one pending slot behind it.
// Latency: push/promote/flush take effect on the next clock edge.
// Backpressure: the owner must not push to pending while pend_vld is high.
module miner_job_buf #(
  parameter int DAT_W = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             flush,
  input  logic             promote,
  input  logic             push,
  input  logic             to_active,
  input  logic [DAT_W-1:0] push_dat,
  output logic             act_vld,
  output logic [DAT_W-1:0] act_dat,
  output logic             pend_vld
);

  logic [DAT_W-1:0] pend_dat;
  logic             act_vld_nxt;
  logic             pend_vld_nxt;
  logic [DAT_W-1:0] act_dat_nxt;
  logic [DAT_W-1:0] pend_dat_nxt;
  logic             pend_live;

  // Ordering within a cycle: flush, then promote, then intake.
  always_comb begin
    act_vld_nxt  = act_vld;
    act_dat_nxt  = act_dat;
    pend_vld_nxt = pend_vld;
    pend_dat_nxt = pend_dat;
    pend_live    = pend_vld && !flush;
    if (flush) begin
      pend_vld_nxt = 1'b0;
    end
    if (promote) begin
      act_vld_nxt  = pend_live;
      act_dat_nxt  = pend_dat;
      pend_vld_nxt = 1'b0;
    end
    if (push) begin
      if (to_active) begin
        act_vld_nxt = 1'b1;
        act_dat_nxt = push_dat;
      end else begin
        pend_vld_nxt = 1'b1;
        pend_dat_nxt = push_dat;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      act_vld  <= 1'b0;
      act_dat  <= '0;
      pend_vld <= 1'b0;
      pend_dat <= '0;
    end else begin
      act_vld  <= act_vld_nxt;
      act_dat  <= act_dat_nxt;
      pend_vld <= pend_vld_nxt;
      pend_dat <= pend_dat_nxt;
    end
  end

endmodule

// File: rtl/miner_job_scheduler.sv
// Sequences one miner core through host jobs, rolling ntime on nonce exhaustion and reporting results.
// Latency: job accepted into an idle scheduler in cycle N gives core_start in cycle N+1.
// Backpressure: job_ready low while pending is occupied; result held until res_ready, no launch meanwhile.
module miner_job_scheduler
  import miner_pkg::*;
#(
  parameter int JOB_ID_W       = 8,
  parameter int MAX_NTIME_ROLL = 4
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [JOB_ID_W-1:0] job_id,
  input  logic [HDR_W-1:0]    job_header,
  input  logic [31:0]         job_nonce_start,
  input  logic                job_flush,
  output logic                core_start,
  output logic                core_use_nonce,
  output logic                core_oneshot,
  output logic [HDR_W-1:0]    core_header,
  output logic [31:0]         core_nonce_in,
  input  logic                core_done,
  input  logic                core_found,
  input  logic [31:0]         core_nonce_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [JOB_ID_W-1:0] res_id,
  output logic                res_found,
  output logic [31:0]         res_nonce,
  output logic [31:0]         res_ntime,
  output logic                busy
);

  localparam int JOB_W = JOB_ID_W + HDR_W + 32;
  localparam int RC_W  = (MAX_NTIME_ROLL > 0) ? $clog2(MAX_NTIME_ROLL + 1) : 1;
  localparam int ARM_W = $clog2(ARM_TIMEOUT);
  localparam logic [RC_W-1:0]  ROLL_MAX = RC_W'(MAX_NTIME_ROLL);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);

  sched_state_t state;
  sched_state_t state_nxt;

  logic                act_vld;
  logic                pend_vld;
  logic [JOB_W-1:0]    act_dat;
  logic [JOB_ID_W-1:0] act_id;
  logic [HDR_W-1:0]    act_hdr;
  logic [31:0]         act_nonce;
  logic [RC_W-1:0]     roll_cnt;
  logic [ARM_W-1:0]    arm_cnt;
  logic                stale;
  logic [31:0]         ntime;

  logic in_flight;
  logic stale_eff;
  logic run_done;
  logic can_roll;
  logic intake;
  logic to_active;
  logic free_active;
  logic promote;

  assign {act_id, act_hdr, act_nonce} = act_dat;

  // ntime is derived rather than stored: it always equals the job's btime plus the sweeps already rolled.
  assign ntime     = act_hdr[BTIME_MSB -: 32] + 32'(roll_cnt);
  assign in_flight = (state == ST_LAUNCH) || (state == ST_ARM) || (state == ST_RUN);
  assign stale_eff = stale || (job_flush && in_flight);
  assign run_done  = (state == ST_RUN) && core_done;
  assign can_roll  = roll_cnt < ROLL_MAX;
  assign intake    = job_valid && job_ready;
  assign to_active = (state == ST_IDLE) && !act_vld;

  assign free_active = (run_done && stale_eff) || ((state == ST_REPORT) && res_ready);
  assign promote     = free_active || ((state == ST_IDLE) && !act_vld && pend_vld);

  miner_job_buf #(
    .DAT_W(JOB_W)
  ) u_job_buf (
    .clk      (clk),
    .arst     (arst),
    .flush    (job_flush),
    .promote  (promote),
    .push     (intake),
    .to_active(to_active),
    .push_dat ({job_id, job_header, job_nonce_start}),
    .act_vld  (act_vld),
    .act_dat  (act_dat),
    .pend_vld (pend_vld)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (act_vld || (intake && to_active)) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: state_nxt = ST_ARM;
      ST_ARM: begin
        if (!core_done) state_nxt = ST_RUN;
        else if (arm_cnt == ARM_LAST) state_nxt = ST_LAUNCH;
      end
      ST_RUN: begin
        if (core_done) begin
          if (stale_eff) state_nxt = ST_IDLE;
          else if (core_found) state_nxt = ST_REPORT;
          else if (can_roll) state_nxt = ST_LAUNCH;
          else state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    core_start     = (state == ST_LAUNCH);
    core_use_nonce = 1'b1;
    core_oneshot   = 1'b0;
    core_nonce_in  = act_nonce;
    core_header    = act_hdr;
    core_header[BTIME_MSB -: 32] = ntime;
    res_valid      = (state == ST_REPORT);
    job_ready      = !pend_vld;
    busy           = (state != ST_IDLE) || pend_vld;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      roll_cnt  <= '0;
      arm_cnt   <= '0;
      stale     <= 1'b0;
      res_id    <= '0;
      res_found <= 1'b0;
      res_nonce <= '0;
      res_ntime <= '0;
    end else begin
      arm_cnt <= (state == ST_ARM) ? arm_cnt + ARM_W'(1) : '0;
      if (run_done && stale_eff) stale <= 1'b0;
      else if (job_flush && in_flight) stale <= 1'b1;
      if (run_done && !stale_eff) begin
        if (core_found || !can_roll) begin
          res_id    <= act_id;
          res_found <= core_found;
          res_nonce <= core_found ? core_nonce_out : 32'd0;
          res_ntime <= ntime;
        end else begin
          roll_cnt <= roll_cnt + RC_W'(1);
        end
      end
      // Every way out of a job leaves the counter clear for whatever becomes active next.
      if (free_active) roll_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Directed bench for miner_job_scheduler with a behavioural core that sweeps a fixed nonce window.
`timescale 1ns/1ps
module tb_miner_job_scheduler;
  import miner_pkg::*;

  logic             clk = 1'b0;
  logic             arst;
  logic             job_valid, job_ready, job_flush;
  logic [7:0]       job_id;
  logic [HDR_W-1:0] job_header;
  logic [31:0]      job_nonce_start;
  logic             core_start, core_use_nonce, core_oneshot;
  logic [HDR_W-1:0] core_header;
  logic [31:0]      core_nonce_in;
  logic             core_done, core_found;
  logic [31:0]      core_nonce_out;
  logic             res_valid, res_ready, res_found, busy;
  logic [7:0]       res_id;
  logic [31:0]      res_nonce, res_ntime;

  int total = 0;
  int bad = 0;

  // Behavioural core controls and start log.
  bit          m_hit_en = 1'b0;
  logic [31:0] m_win = '0;
  int          m_len = 8;
  int          m_cnt = 0;
  logic [31:0] m_base = '0;
  int          n_starts = 0;
  logic [31:0] start_btime [64];

  always #5 clk = ~clk;

  miner_job_scheduler #(.JOB_ID_W(8), .MAX_NTIME_ROLL(2)) dut (
    .clk(clk), .arst(arst),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
    .job_header(job_header), .job_nonce_start(job_nonce_start), .job_flush(job_flush),
    .core_start(core_start), .core_use_nonce(core_use_nonce), .core_oneshot(core_oneshot),
    .core_header(core_header), .core_nonce_in(core_nonce_in),
    .core_done(core_done), .core_found(core_found), .core_nonce_out(core_nonce_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_found(res_found),
    .res_nonce(res_nonce), .res_ntime(res_ntime), .busy(busy)
  );

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      core_done      <= 1'b1;
      core_found     <= 1'b0;
      core_nonce_out <= '0;
      m_cnt          <= 0;
    end else if (core_start) begin
      core_done  <= 1'b0;
      core_found <= 1'b0;
      m_cnt      <= m_len;
      m_base     <= core_nonce_in;
      start_btime[n_starts % 64] <= core_header[BTIME_MSB -: 32];
      n_starts   <= n_starts + 1;
    end else if (!core_done) begin
      if (m_cnt <= 1) begin
        core_done <= 1'b1;
        if (m_hit_en && ((m_win - m_base) < 32'(m_len))) begin
          core_found     <= 1'b1;
          core_nonce_out <= m_win;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  function automatic logic [HDR_W-1:0] mk_hdr(input logic [31:0] btime, input logic [31:0] bits);
    logic [HDR_W-1:0] h;
    for (int i = 0; i < HDR_WORDS; i++) h[hdr_msb(i) -: 32] = 32'hA500_0000 + 32'(i) * 32'h0101_0101;
    h[BTIME_MSB -: 32] = btime;
    h[BITS_MSB -: 32]  = bits;
    return h;
  endfunction

  // Holds job_valid until accepted; call and return on a falling edge.
  task automatic offer(input logic [7:0] id, input logic [31:0] btime, input logic [31:0] nonce,
                       output bit ok);
    job_valid = 1'b1; job_id = id; job_header = mk_hdr(btime, 32'h1705_AE3A);
    job_nonce_start = nonce; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (job_ready) ok = 1'b1;
      @(negedge clk);
    end
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (res_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; job_valid = 1'b0; job_flush = 1'b0; res_ready = 1'b0;
    job_id = '0; job_header = '0; job_nonce_start = '0;
    #12;
    total++; if (core_start !== 1'b0) begin $display("FAIL reset core_start got %b want 0", core_start); bad++; end
    total++; if (res_valid !== 1'b0) begin $display("FAIL reset res_valid got %b want 0", res_valid); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL reset busy got %b want 0", busy); bad++; end
    total++; if (job_ready !== 1'b1) begin $display("FAIL reset job_ready got %b want 1", job_ready); bad++; end
    total++; if ({res_id, res_found, res_nonce, res_ntime} !== '0) begin
      $display("FAIL reset res_fields got %h/%b/%h/%h want 0", res_id, res_found, res_nonce, res_ntime); bad++; end
    total++; if ({core_use_nonce, core_oneshot} !== 2'b10) begin
      $display("FAIL reset ties got %b%b want 10", core_use_nonce, core_oneshot); bad++; end
    @(negedge clk); arst = 1'b0; @(negedge clk);
  endtask

  task automatic test_found();
    bit ok; int s0;
    s0 = n_starts; m_hit_en = 1'b1; m_win = 32'h1DAC_2B7C; m_len = 32;
    offer(8'd5, 32'h5F5E_1000, 32'h1DAC_2B70, ok);
    total++; if (!ok) begin $display("FAIL t1 accept got timeout want handshake"); bad++; end
    total++; if (core_start !== 1'b1) begin $display("FAIL t1 start_n1 got %b want 1", core_start); bad++; end
    total++; if (core_nonce_in !== 32'h1DAC_2B70) begin $display("FAIL t1 nonce_in got %h want 1dac2b70", core_nonce_in); bad++; end
    total++; if (core_header[BTIME_MSB -: 32] !== 32'h5F5E_1000 || core_header[BITS_MSB -: 32] !== 32'h1705_AE3A) begin
      $display("FAIL t1 header got %h/%h want 5f5e1000/1705ae3a", core_header[BTIME_MSB -: 32], core_header[BITS_MSB -: 32]); bad++; end
    @(negedge clk);
    total++; if (core_start !== 1'b0) begin $display("FAIL t1 start_single got %b want 0", core_start); bad++; end
    wait_res(100, ok);
    total++; if (!ok) begin $display("FAIL t1 res_wait got timeout want res_valid"); bad++; end
    total++; if ({res_found, res_nonce, res_id, res_ntime} !== {1'b1, 32'h1DAC_2B7C, 8'd5, 32'h5F5E_1000}) begin
      $display("FAIL t1 result got %b/%h/%h/%h want 1/1dac2b7c/05/5f5e1000", res_found, res_nonce, res_id, res_ntime); bad++; end
    total++; if (n_starts - s0 != 1) begin $display("FAIL t1 starts got %0d want 1", n_starts - s0); bad++; end
    consume();
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL t1 after_consume got valid=%b busy=%b want 0/0", res_valid, busy); bad++; end
  endtask

  // Always-exhausting core with two rolls allowed: three sweeps, one not-found result.
  task automatic test_roll(input logic [7:0] id, input logic [31:0] bt, input string nm);
    bit ok; int s0;
    s0 = n_starts; m_hit_en = 1'b0; m_len = 8;
    offer(id, bt, 32'h0000_1000, ok);
    wait_res(300, ok);
    total++; if (!ok) begin $display("FAIL %s res_wait got timeout want res_valid", nm); bad++; end
    total++; if (n_starts - s0 != 3) begin $display("FAIL %s starts got %0d want 3", nm, n_starts - s0); bad++; end
    for (int k = 0; k < 3; k++) begin
      total++; if (start_btime[(s0 + k) % 64] !== bt + 32'(k)) begin
        $display("FAIL %s btime%0d got %h want %h", nm, k, start_btime[(s0 + k) % 64], bt + 32'(k)); bad++; end
    end
    total++; if ({res_found, res_nonce, res_id, res_ntime} !== {1'b0, 32'd0, id, bt + 32'd2}) begin
      $display("FAIL %s result got %b/%h/%h/%h want 0/0/%h/%h", nm, res_found, res_nonce, res_id, res_ntime, id, bt + 32'd2); bad++; end
    consume();
  endtask

  task automatic test_back_to_back();
    bit ok; bit take; int s0; int nres; logic [7:0] got [3];
    s0 = n_starts; m_hit_en = 1'b1; m_win = 32'h0000_1005; m_len = 16; nres = 0;
    offer(8'd10, 32'h6000_0000, 32'h0000_1000, ok);
    offer(8'd11, 32'h6000_0100, 32'h0000_1000, ok);
    job_valid = 1'b1; job_id = 8'd12; job_header = mk_hdr(32'h6000_0200, 32'h1705_AE3A);
    total++; if (job_ready !== 1'b0) begin $display("FAIL t3 ready_full got %b want 0", job_ready); bad++; end
    for (int c = 0; c < 400 && nres < 3; c++) begin
      if (c == 50) begin
        total++; if (n_starts - s0 != 1 || job_ready !== 1'b0) begin
          $display("FAIL t3 held got starts=%0d ready=%b want 1/0", n_starts - s0, job_ready); bad++; end
        total++; if (res_valid !== 1'b1 || res_id !== 8'd10) begin
          $display("FAIL t3 first_res got %b/%h want 1/0a", res_valid, res_id); bad++; end
        res_ready = 1'b1;
      end
      take = job_valid && job_ready;
      if (res_valid && res_ready) begin got[nres] = res_id; nres++; end
      @(negedge clk);
      if (take) job_valid = 1'b0;
    end
    res_ready = 1'b0; job_valid = 1'b0;
    total++; if (nres != 3) begin $display("FAIL t3 nres got %0d want 3", nres); bad++; end
    for (int k = 0; k < 3 && k < nres; k++) begin
      total++; if (got[k] !== 8'(10 + k)) begin $display("FAIL t3 order%0d got %h want %h", k, got[k], 8'(10 + k)); bad++; end
    end
    total++; if (n_starts - s0 != 3) begin $display("FAIL t3 starts got %0d want 3", n_starts - s0); bad++; end
  endtask

  task automatic test_flush();
    bit ok; int s0;
    s0 = n_starts; m_hit_en = 1'b1; m_win = 32'h0000_2003; m_len = 20;
    offer(8'd20, 32'h3000_0000, 32'h0000_2000, ok);
    offer(8'd21, 32'h3100_0000, 32'h0000_2000, ok);
    repeat (3) @(negedge clk);
    total++; if (core_done !== 1'b0 || job_ready !== 1'b0) begin
      $display("FAIL t4 pre_flush got done=%b ready=%b want 0/0", core_done, job_ready); bad++; end
    job_flush = 1'b1; job_valid = 1'b1; job_id = 8'd22; job_header = mk_hdr(32'h3333_0000, 32'h1705_AE3A);
    @(negedge clk);
    job_flush = 1'b0;
    offer(8'd22, 32'h3333_0000, 32'h0000_2000, ok);
    total++; if (!ok) begin $display("FAIL t4 accept got timeout want handshake"); bad++; end
    wait_res(200, ok);
    total++; if (!ok || res_id !== 8'd22 || res_found !== 1'b1) begin
      $display("FAIL t4 result got ok=%b id=%h found=%b want 1/16/1", ok, res_id, res_found); bad++; end
    total++; if (n_starts - s0 != 2 || start_btime[(s0 + 1) % 64] !== 32'h3333_0000) begin
      $display("FAIL t4 starts got %0d/%h want 2/33330000", n_starts - s0, start_btime[(s0 + 1) % 64]); bad++; end
    consume();
    total++; if (busy !== 1'b0) begin $display("FAIL t4 idle got busy=%b want 0", busy); bad++; end
  endtask

  task automatic test_arst();
    bit ok;
    m_hit_en = 1'b1; m_win = 32'h0000_3004; m_len = 30;
    offer(8'd40, 32'h4000_0000, 32'h0000_3000, ok);
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1 || core_done !== 1'b0) begin
      $display("FAIL t6 running got busy=%b done=%b want 1/0", busy, core_done); bad++; end
    arst = 1'b1;
    #1;
    total++; if ({core_start, res_valid, busy, job_ready} !== 4'b0001 || {res_id, res_ntime} !== '0) begin
      $display("FAIL t6 reset_outs got %b%b%b%b id=%h nt=%h want 0001/0/0", core_start, res_valid, busy, job_ready, res_id, res_ntime); bad++; end
    @(negedge clk); arst = 1'b0; @(negedge clk);
    offer(8'd41, 32'h4100_0000, 32'h0000_3000, ok);
    wait_res(200, ok);
    total++; if (!ok || {res_id, res_found, res_nonce, res_ntime} !== {8'd41, 1'b1, 32'h0000_3004, 32'h4100_0000}) begin
      $display("FAIL t6 fresh got ok=%b %h/%b/%h/%h want 1 29/1/00003004/41000000", ok, res_id, res_found, res_nonce, res_ntime); bad++; end
    consume();
  endtask

  initial begin
    test_reset();
    test_found();
    test_roll(8'd7, 32'h5F00_0000, "t2");
    test_back_to_back();
    test_flush();
    test_roll(8'd9, 32'hFFFF_FFFF, "t5");
    test_arst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
